// File: rtl/riscv_io_pkg.sv
// Shared MMIO map and status-word layout for the RISC-V character I/O ports.
// Used by the keyboard receive path and its neighbours on the data bus.
package riscv_io_pkg;

   localparam logic [31:0] VGA_CHAR_ADDR = 32'd7756;
   localparam logic [31:0] KBD_DATA_ADDR = 32'd7760;
   localparam logic [31:0] KBD_STAT_ADDR = 32'd7764;
   localparam logic [31:0] KBD_CTRL_ADDR = 32'd7768;

   localparam int STAT_EMPTY_BIT = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_OVF_BIT   = 2;
   localparam int STAT_CNT_LSB   = 8;

   localparam int CTRL_FLUSH_BIT = 0;
   localparam int CTRL_OVFCLR_BIT = 1;

   typedef struct packed {
      logic [15:0] rsvd_hi;
      logic [7:0]  count;
      logic [4:0]  rsvd_lo;
      logic        overflow;
      logic        full;
      logic        empty;
   } kbd_stat_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with occupancy count and one-cycle flush.
// Push is accepted when not full, or when a real pop happens the same cycle.
module sync_byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [7:0]               i_din,
   output logic [7:0]               o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_do_pop;
   logic w_do_push;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !w_empty && !i_flush;
   assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_din;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

// File: rtl/connect_kbd_riscv.sv
// Keyboard receive port: buffers ASCII bytes and exposes them to the core
// as memory-mapped data, status and control registers.
module connect_kbd_riscv
   import riscv_io_pkg::*;
#(
   parameter int          DEPTH     = 16,
   parameter logic [31:0] DATA_ADDR = KBD_DATA_ADDR,
   parameter logic [31:0] STAT_ADDR = KBD_STAT_ADDR,
   parameter logic [31:0] CTRL_ADDR = KBD_CTRL_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read_en,
   input  logic        write_en,
   input  logic [31:0] data_wr,
   input  logic [7:0]  ascii_in,
   input  logic        ascii_valid,
   output logic [31:0] data_rd,
   output logic        rd_hit,
   output logic        rx_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [7:0]    w_head;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_data_ld;
   logic          w_stat_ld;
   logic          w_ctrl_st;
   logic          w_flush;
   logic          w_ovf_clr;
   logic          w_ovf_evt;
   logic          w_pop;
   kbd_stat_t     w_stat;
   logic          w_unused;

   logic [31:0]   r_data_rd;
   logic          r_rd_hit;
   logic          r_ovf;

   assign w_data_ld = read_en && (address == DATA_ADDR);
   assign w_stat_ld = read_en && (address == STAT_ADDR);
   assign w_ctrl_st = write_en && !read_en && (address == CTRL_ADDR);
   assign w_flush   = w_ctrl_st && data_wr[CTRL_FLUSH_BIT];
   assign w_ovf_clr = w_stat_ld
                   || (w_ctrl_st && data_wr[CTRL_OVFCLR_BIT]);
   assign w_pop     = w_data_ld && !w_empty;
   // A byte lost to a full FIFO; a flush discards it silently instead.
   assign w_ovf_evt = ascii_valid && !w_flush && w_full && !w_pop;
   assign w_unused  = ^data_wr[31:2];

   sync_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (ascii_valid),
      .i_pop   (w_data_ld),
      .i_flush (w_flush),
      .i_din   (ascii_in),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_stat          = '0;
      w_stat.count    = 8'(w_count);
      w_stat.overflow = r_ovf;
      w_stat.full     = w_full;
      w_stat.empty    = w_empty;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_evt) begin
         r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data_rd <= '0;
         r_rd_hit  <= 1'b0;
      end else begin
         r_rd_hit <= w_data_ld || w_stat_ld;
         unique case (1'b1)
            w_data_ld: r_data_rd <= {24'h0, w_empty ? 8'h00 : w_head};
            w_stat_ld: r_data_rd <= w_stat;
            default:   r_data_rd <= '0;
         endcase
      end
   end

   assign data_rd  = r_data_rd;
   assign rd_hit   = r_rd_hit;
   assign rx_ready = !w_empty;

endmodule

// File: tb/tb_connect_kbd_riscv.sv
// Scoreboard bench for connect_kbd_riscv: driver feeds a byte-queue model,
// monitor checks each cycle's load response and rx_ready.
module tb_connect_kbd_riscv;

   localparam int          DEPTH = 16;
   localparam logic [31:0] A_VGA  = 32'd7756;
   localparam logic [31:0] A_DATA = 32'd7760;
   localparam logic [31:0] A_STAT = 32'd7764;
   localparam logic [31:0] A_CTRL = 32'd7768;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] address = '0;
   logic        read_en = 1'b0;
   logic        write_en = 1'b0;
   logic [31:0] data_wr = '0;
   logic [7:0]  ascii_in = '0;
   logic        ascii_valid = 1'b0;
   logic [31:0] data_rd;
   logic        rd_hit;
   logic        rx_ready;

   connect_kbd_riscv #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .address     (address),
      .read_en     (read_en),
      .write_en    (write_en),
      .data_wr     (data_wr),
      .ascii_in    (ascii_in),
      .ascii_valid (ascii_valid),
      .data_rd     (data_rd),
      .rd_hit      (rd_hit),
      .rx_ready    (rx_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  mq[$];
   bit          m_ovf;
   int          cyc;
   int          total;
   int          bad;
   int          max_cnt;

   initial begin
      cyc = 0;
      total = 0;
      bad = 0;
      m_ovf = 1'b0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h want %h",
                  name, cyc, act, req);
      end
   endtask

   // Monitor: the load issued before edge N is due at edge N.
   always @(posedge clk) begin
      #1;
      if (reset) begin
         if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            check("rd_hit", 32'(rd_hit), 32'd1);
            check("data_rd", data_rd, exp_q[0].data);
            void'(exp_q.pop_front());
         end else begin
            check("idle_hit", 32'(rd_hit), 32'd0);
            check("idle_data", data_rd, 32'd0);
         end
         check("rx_ready", 32'(rx_ready), 32'(mq.size() != 0));
      end
   end

   function automatic void model_step(input bit av, input logic [7:0] a,
                                      input bit rd, input bit wr,
                                      input logic [31:0] addr,
                                      input logic [31:0] wd);
      bit   dl, sl, cs, fl, evt;
      exp_t e;
      dl = rd && addr == A_DATA;
      sl = rd && addr == A_STAT;
      cs = wr && !rd && addr == A_CTRL;
      fl = cs && wd[0];
      evt = 1'b0;
      e.due = cyc + 1;
      if (sl) begin
         e.data = {16'h0, 8'(mq.size()), 5'h0, m_ovf,
                   mq.size() == DEPTH, mq.size() == 0};
         exp_q.push_back(e);
      end
      if (dl) begin
         e.data = (mq.size() == 0) ? 32'h0 : {24'h0, mq[0]};
         exp_q.push_back(e);
         if (!fl && mq.size() != 0)
            void'(mq.pop_front());
      end
      if (fl)
         mq.delete();
      else if (av) begin
         if (mq.size() < DEPTH) mq.push_back(a);
         else evt = 1'b1;
      end
      if (evt) m_ovf = 1'b1;
      else if (sl || (cs && wd[1])) m_ovf = 1'b0;
      if (mq.size() > max_cnt) max_cnt = mq.size();
   endfunction

   task automatic op(input bit av, input logic [7:0] a, input bit rd,
                     input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd);
      @(negedge clk);
      ascii_valid = av;
      ascii_in = a;
      read_en = rd;
      write_en = wr;
      address = addr;
      data_wr = wd;
      model_step(av, a, rd, wr, addr, wd);
   endtask

   task automatic idle();
      op(0, 8'h0, 0, 0, 32'h0, 32'h0);
   endtask

   task automatic push(input logic [7:0] a);
      op(1, a, 0, 0, 32'h0, 32'h0);
   endtask

   task automatic ld(input logic [31:0] addr);
      op(0, 8'h0, 1, 0, addr, 32'h0);
   endtask

   initial begin
      logic [31:0] addrs [5];
      logic [31:0] ra;
      addrs[0] = A_VGA;
      addrs[1] = A_DATA;
      addrs[2] = A_STAT;
      addrs[3] = A_CTRL;
      addrs[4] = 32'h0001_1E50;
      #2;
      check("rst_data", data_rd, 32'h0);
      check("rst_hit", 32'(rd_hit), 32'h0);
      check("rst_ready", 32'(rx_ready), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // asynchronous reset with data buffered
      push(8'h41);
      push(8'h42);
      ld(A_STAT);
      idle();
      @(posedge clk);
      #3;
      reset = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      #1;
      check("mid_rst_data", data_rd, 32'h0);
      check("mid_rst_hit", 32'(rd_hit), 32'h0);
      check("mid_rst_ready", 32'(rx_ready), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      ld(A_STAT);

      // in-order read and empty load
      push(8'h48);
      push(8'h69);
      ld(A_DATA);
      ld(A_DATA);
      ld(A_DATA);
      ld(A_STAT);

      // overflow
      for (int i = 0; i < 17; i++) push(8'(8'h30 + i));
      ld(A_STAT);
      for (int i = 0; i < 16; i++) ld(A_DATA);
      ld(A_STAT);

      // full plus simultaneous push/pop
      for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
      op(1, 8'h7A, 1, 0, A_DATA, 32'h0);
      ld(A_STAT);
      for (int i = 0; i < 16; i++) ld(A_DATA);
      ld(A_STAT);

      // wrap-around, count capped at 1
      max_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         push(8'($urandom));
         ld(A_DATA);
      end
      check("wrap_max", 32'(max_cnt), 32'd1);

      // flush and decode
      push(8'h01);
      push(8'h02);
      push(8'h03);
      op(0, 8'h0, 0, 1, A_CTRL, 32'h1);
      ld(A_STAT);
      ld(A_VGA);
      push(8'h04);
      op(0, 8'h0, 0, 1, A_DATA, 32'hFF);
      op(0, 8'h0, 0, 1, A_STAT, 32'h3);
      ld(A_STAT);
      ld(A_DATA);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit rd, wr;
         ra = addrs[$urandom_range(4)];
         rd = ($urandom_range(2) == 0);
         wr = ($urandom_range(3) == 0);
         op($urandom_range(1), 8'($urandom), rd, wr, ra,
            $urandom & 32'h7);
      end
      ld(A_STAT);
      for (int i = 0; i < 4; i++) idle();
      @(posedge clk);
      #2;
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
